// File: rtl/seg_scan_if.sv
// Bundles the frame-staging handshake and display drive signals of the scan controller.
// The master side stages frames and supplies the graphic segment map; the slave side is the controller.
interface seg_scan_if;
    logic        load;
    logic [31:0] data;
    logic        graph_mode;
    logic [7:0]  point;
    logic [7:0]  blank;
    logic [7:0]  seg_graph;
    logic        busy;
    logic        ack;
    logic [2:0]  scan;
    logic [31:0] disp_data;
    logic [7:0]  an;
    logic [7:0]  seg;

    // load is accepted on any rising clk edge where busy is low; while busy is high,
    // load is ignored. ack pulses for one cycle once the staged frame becomes visible.
    modport master (
        output load, data, graph_mode, point, blank, seg_graph,
        input  busy, ack, scan, disp_data, an, seg
    );

    modport slave (
        input  load, data, graph_mode, point, blank, seg_graph,
        output busy, ack, scan, disp_data, an, seg
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with double-buffered frames.
// New frames are staged in a shadow copy and only become visible at a frame boundary.
module seg_scan_ctrl #(
    parameter int DIV_W = 17
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       scan;
    logic             pending;
    logic             ack;

    logic [31:0]      sh_data;
    logic             sh_mode;
    logic [7:0]       sh_dpt;
    logic [7:0]       sh_blk;

    logic [31:0]      disp_data;
    logic             mode;
    logic [7:0]       dpt;
    logic [7:0]       blk;

    logic             tick;
    logic             frame_end;
    logic [3:0]       nibble;
    logic [6:0]       hex_seg;

    assign tick      = &div_cnt;
    assign frame_end = tick && (scan == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            scan      <= '0;
            pending   <= 1'b0;
            ack       <= 1'b0;
            sh_data   <= '0;
            sh_mode   <= 1'b0;
            sh_dpt    <= '0;
            sh_blk    <= '0;
            disp_data <= '0;
            mode      <= 1'b0;
            dpt       <= '0;
            blk       <= 8'hFF;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            ack     <= 1'b0;
            if (tick) begin
                scan <= scan + 3'd1;
            end
            // Commit only ever happens with pending set, so a load landing on the
            // same frame_end with pending clear falls through to staging.
            if (frame_end && pending) begin
                disp_data <= sh_data;
                mode      <= sh_mode;
                dpt       <= sh_dpt;
                blk       <= sh_blk;
                pending   <= 1'b0;
                ack       <= 1'b1;
            end else if (bus.load && !pending) begin
                sh_data <= bus.data;
                sh_mode <= bus.graph_mode;
                sh_dpt  <= bus.point;
                sh_blk  <= bus.blank;
                pending <= 1'b1;
            end
        end
    end

    assign nibble = disp_data[4*scan +: 4];

    always_comb begin
        hex_seg = 7'h7F;
        case (nibble)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            4'hF: hex_seg = 7'h0E;
            default: hex_seg = 7'h7F;
        endcase
    end

    assign bus.busy      = pending;
    assign bus.ack       = ack;
    assign bus.scan      = scan;
    assign bus.disp_data = disp_data;
    assign bus.an        = blk[scan] ? 8'hFF : ~(8'b1 << scan);
    assign bus.seg       = mode ? bus.seg_graph : {~dpt[scan], hex_seg};

endmodule
